pll_reset_sequencer: RTL and testbench

//  Controls the system PLL from the consuming side: drives the PLL reset, watches its locked output,
//  and releases a synchronous system reset only after lock has been stable for a set time.

---
 rtl/pll_reset_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset. Retries on lock timeout, re-sequences on lock
// loss, and latches a hard failure once the retry budget is spent.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 65535,
  parameter int unsigned LOCK_STABLE      = 1024,
  parameter int unsigned RETRY_MAX        = 3,
  parameter int unsigned CNT_W            = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic             fail,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // One shared timer serves all three timed phases, so it is sized for the longest.
  localparam int unsigned MAX_A = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int unsigned MAX_T = (MAX_A > RST_PULSE_CYCLES) ? MAX_A : RST_PULSE_CYCLES;
  localparam int TW = $clog2(MAX_T + 1);
  // Retry counter holds RETRY_MAX plus one spare code so saturation never masks the limit.
  localparam int RW = $clog2(RETRY_MAX + 2);

  localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(RETRY_MAX);

  state_e             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [RW-1:0]      retry_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync2_q;
  logic               pll_rst_q, sys_reset_n_q, fail_q;
  logic               locked_s;

  assign locked_s = sync2_q;

  // Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state decode; relock_req is applied last so it overrides any transition.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    retry_inc = (retry_q != '1) ? retry_q + 1'b1 : retry_q;

    case (state_q)
      ST_RST_PLL: begin
        if (timer_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          retry_d = retry_inc;
          if ((RETRY_MAX != 0) && (retry_inc == RETRY_LIMIT)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_RST_PLL;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = ST_RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RST_PLL;
          timer_d = '0;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RST_PLL;
        timer_d = '0;
      end
    endcase

    if (relock_req) begin
      state_d = ST_RST_PLL;
      timer_d = '0;
      retry_d = '0;
    end
  end

  // Sequencer state and outputs, registered from the decoded next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RST_PLL;
      timer_q       <= '0;
      retry_q       <= '0;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
      sys_reset_n_q <= (state_d == ST_RUN);
      fail_q        <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with short timing parameters
// (pulse 4, timeout 20, stable 8, two attempts before failure).
module tb_pll_reset_sequencer;

  localparam int SEL_RST   = 0;
  localparam int SEL_SYSN  = 1;
  localparam int SEL_STATE = 2;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       fail;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_o;

  int checkCount;
  int failCount;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT    (20),
    .LOCK_STABLE     (8),
    .RETRY_MAX       (2),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .sys_reset_n  (sys_reset_n),
    .fail         (fail),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o      (state_o)
  );

  // 100 MHz simulation clock; only cycle counts matter here.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      SEL_RST:  return {7'd0, pll_rst};
      SEL_SYSN: return {7'd0, sys_reset_n};
      default:  return {5'd0, state_o};
    endcase
  endfunction

  // Count clocks until the selected output equals val; -1 if the bound expires.
  task automatic waitSignal(input int sel, input logic [7:0] val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (probe(sel) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus();
    int n;
    int n0;
    int bad;

    // Reset values while reset_n is held low.
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_pll_rst", pll_rst, 1);
    checkOutput("rst_sysn", sys_reset_n, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_cnt", lock_loss_cnt, 0);

    // Clean bring-up: 4-cycle pulse, lock 3 cycles later, release 11 cycles after lock.
    reset_n = 1'b1;
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t1_pulse_len", n, 4);
    checkOutput("t1_wait_state", state_o, 1);
    repeat (3) tick();
    pll_locked = 1'b1;
    waitSignal(SEL_SYSN, 1, 40, n);
    checkOutput("t1_release_latency", n, 11);
    checkOutput("t1_run_state", state_o, 3);
    checkOutput("t1_fail", fail, 0);
    checkOutput("t1_cnt", lock_loss_cnt, 0);

    // No lock ever: two attempts, then a sticky failure.
    pll_locked = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t2_pulse1", n, 4);
    waitSignal(SEL_RST, 1, 40, n);
    checkOutput("t2_wait1", n, 20);
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t2_pulse2", n, 4);
    waitSignal(SEL_STATE, 4, 40, n);
    checkOutput("t2_wait2_to_fail", n, 20);
    checkOutput("t2_fail", fail, 1);
    checkOutput("t2_fail_pll_rst", pll_rst, 1);
    checkOutput("t2_fail_sysn", sys_reset_n, 0);
    repeat (5) tick();
    checkOutput("t2_fail_sticky", state_o, 4);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checkOutput("t2_relock_state", state_o, 0);
    checkOutput("t2_relock_fail", fail, 0);
    checkOutput("t2_relock_pll_rst", pll_rst, 1);
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t2_relock_pulse", n, 4);

    // Lock, run, one-cycle lock drop, re-sequence, then relock back to run.
    pll_locked = 1'b1;
    waitSignal(SEL_SYSN, 1, 40, n);
    checkOutput("t3_release_latency", n, 11);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    waitSignal(SEL_SYSN, 0, 10, n);
    checkOutput("t3_loss_latency", n + 1, 3);
    checkOutput("t3_cnt", lock_loss_cnt, 1);
    checkOutput("t3_state", state_o, 0);
    checkOutput("t3_pll_rst", pll_rst, 1);
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t3_pulse", n, 4);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    waitSignal(SEL_SYSN, 1, 40, n);
    checkOutput("t3_relock_to_run", n, 13);
    checkOutput("t3_cnt_hold", lock_loss_cnt, 1);

    // Glitch while stable at timer=5 sends it back to wait; a full stable window follows.
    pll_locked = 1'b0;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checkOutput("t4_relock_no_count", lock_loss_cnt, 1);
    waitSignal(SEL_STATE, 1, 20, n);
    checkOutput("t4_to_wait", n, 4);
    pll_locked = 1'b1;
    waitSignal(SEL_STATE, 2, 20, n);
    checkOutput("t4_to_stable", n, 3);
    repeat (3) tick();
    checkOutput("t4_still_stable", state_o, 2);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    waitSignal(SEL_STATE, 1, 10, n);
    checkOutput("t4_glitch_to_wait", n, 2);
    waitSignal(SEL_SYSN, 1, 30, n);
    checkOutput("t4_full_stable", n, 9);
    checkOutput("t4_run", state_o, 3);

    // Asynchronous reset in the middle of a cycle, first in RUN then in STABLE.
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5_run_state", state_o, 0);
    checkOutput("t5_run_pll_rst", pll_rst, 1);
    checkOutput("t5_run_sysn", sys_reset_n, 0);
    checkOutput("t5_run_fail", fail, 0);
    checkOutput("t5_run_cnt", lock_loss_cnt, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t5_pulse_a", n, 4);
    waitSignal(SEL_STATE, 2, 10, n);
    checkOutput("t5_to_stable", n, 1);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5_stable_state", state_o, 0);
    checkOutput("t5_stable_pll_rst", pll_rst, 1);
    checkOutput("t5_stable_sysn", sys_reset_n, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    waitSignal(SEL_RST, 0, 20, n);
    checkOutput("t5_pulse_b", n, 4);
    waitSignal(SEL_SYSN, 1, 30, n);
    checkOutput("t5_run_again", n, 9);

    // Lock loss coinciding with relock_req still counts.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checkOutput("t6_simul_cnt", lock_loss_cnt, 1);
    checkOutput("t6_simul_state", state_o, 0);
    waitSignal(SEL_SYSN, 1, 40, n);
    checkOutput("t6_simul_to_run", n, 13);

    // Drive the loss counter to saturation and one step beyond.
    bad = 0;
    for (int k = 0; k < 254; k++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      waitSignal(SEL_SYSN, 0, 10, n0);
      waitSignal(SEL_SYSN, 1, 40, n);
      if (n0 != 2 || n != 13) bad++;
    end
    checkOutput("t6_loop_latency_errors", bad, 0);
    checkOutput("t6_cnt_255", lock_loss_cnt, 255);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    waitSignal(SEL_SYSN, 0, 10, n0);
    checkOutput("t6_sat_loss", n0, 2);
    checkOutput("t6_cnt_saturated", lock_loss_cnt, 255);
    waitSignal(SEL_SYSN, 1, 40, n);
    checkOutput("t6_sat_run", n, 13);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
